pusch_re_mapper: RTL and testbench

Parametrised resource-element mapper between the transform-precoding FFT and the IFFT in the PUSCH transmit chain. For each OFDM symbol of a slot it emits one full N_FFT-bin frame in natural bin order. Bins inside the allocated subcarrier window carry either precoded data or DMRS, selected by a per-symbol mask. All other bins are zero. DMRS comb mode and all geometry are run-time configurable, and every stream uses valid/ready back-pressure.

---
 rtl/pusch_pkg.sv | 19 +
 rtl/pusch_re_mapper_re_classifier.sv | 38 +++
 rtl/pusch_re_mapper.sv | 210 +++++++++++++++++++++
 tb/tb_pusch_re_mapper.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pusch_pkg.sv
// Shared types for the PUSCH resource-element mapper: controller states and
// per-bin resource-element classes.
package pusch_pkg;

  localparam int MAX_SYMBOLS = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAP,
    ST_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    RE_ZERO,
    RE_DATA,
    RE_DMRS
  } re_class_t;

endpackage

// File: rtl/pusch_re_mapper_re_classifier.sv
// Combinational classifier: decides whether a bin of a symbol carries data,
// DMRS or a forced zero, from the latched allocation window and DMRS layout.
module re_classifier
  import pusch_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic [AW-1:0] bin_cnt,
  input  logic [3:0]    sym_cnt,
  input  logic [AW-1:0] sc_start,
  input  logic [AW:0]   n_sc,
  input  logic [13:0]   dmrs_mask,
  input  logic          dmrs_comb,
  output re_class_t     re_class
);

  logic [AW:0] win_end;
  logic        in_win;
  logic        odd_offset;
  logic [15:0] mask_ext;

  always_comb begin
    // The window end is at most N_FFT because the config is range-checked at start.
    win_end    = {1'b0, sc_start} + n_sc;
    in_win     = ({1'b0, bin_cnt} >= {1'b0, sc_start}) && ({1'b0, bin_cnt} < win_end);
    odd_offset = bin_cnt[0] ^ sc_start[0];
    mask_ext   = {2'b00, dmrs_mask};
    re_class   = RE_ZERO;
    if (in_win) begin
      if (mask_ext[sym_cnt]) begin
        if (!(dmrs_comb && odd_offset)) re_class = RE_DMRS;
      end else begin
        re_class = RE_DATA;
      end
    end
  end

endmodule

// File: rtl/pusch_re_mapper.sv
// PUSCH RE mapper: emits one N_FFT-bin frame per OFDM symbol, placing data or
// DMRS inside the allocated window and zeros elsewhere, with valid/ready flow.
module pusch_re_mapper
  import pusch_pkg::*;
#(
  parameter int N_FFT      = 2048,
  parameter int WIDTH      = 26,
  parameter int D_W        = 18,
  parameter int DMRS_W     = 9,
  parameter int DMRS_SHIFT = 8,
  localparam int AW        = $clog2(N_FFT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        cfg_n_symbol,
  input  logic [AW-1:0]     cfg_sc_start,
  input  logic [AW:0]       cfg_n_sc,
  input  logic [13:0]       cfg_dmrs_mask,
  input  logic              cfg_dmrs_comb,
  input  logic [D_W-1:0]    d_re,
  input  logic [D_W-1:0]    d_im,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [DMRS_W-1:0] rs_re,
  input  logic [DMRS_W-1:0] rs_im,
  input  logic              rs_valid,
  output logic              rs_ready,
  output logic [WIDTH-1:0]  out_re,
  output logic [WIDTH-1:0]  out_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [3:0]        out_sym,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_t           state_q, state_d;
  logic [AW-1:0]    bin_cnt_q, bin_cnt_d;
  logic [3:0]       sym_cnt_q, sym_cnt_d;
  logic [3:0]       n_symbol_q, n_symbol_d;
  logic [AW-1:0]    sc_start_q, sc_start_d;
  logic [AW:0]      n_sc_q, n_sc_d;
  logic [13:0]      mask_q, mask_d;
  logic             comb_q, comb_d;
  logic [WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [3:0]       out_sym_q, out_sym_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  re_class_t        re_class;
  logic             adv;
  logic             load;
  logic             cfg_bad;
  logic [AW+1:0]    win_sum;
  logic [WIDTH-1:0] load_re, load_im;

  re_classifier #(.AW(AW)) u_classifier (
    .bin_cnt   (bin_cnt_q),
    .sym_cnt   (sym_cnt_q),
    .sc_start  (sc_start_q),
    .n_sc      (n_sc_q),
    .dmrs_mask (mask_q),
    .dmrs_comb (comb_q),
    .re_class  (re_class)
  );

  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    n_symbol_d  = n_symbol_q;
    sc_start_d  = sc_start_q;
    n_sc_d      = n_sc_q;
    mask_d      = mask_q;
    comb_d      = comb_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_sym_d   = out_sym_q;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q;
    d_ready     = 1'b0;
    rs_ready    = 1'b0;
    load        = 1'b0;
    load_re     = '0;
    load_im     = '0;
    adv         = !out_valid_q || out_ready;
    win_sum     = {2'b00, cfg_sc_start} + {1'b0, cfg_n_sc};
    cfg_bad     = (win_sum > (AW+2)'(N_FFT)) || (cfg_n_sc == '0) ||
                  (cfg_n_symbol == 4'd0) || (cfg_n_symbol > 4'(MAX_SYMBOLS));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_err_d = cfg_bad;
          if (!cfg_bad) begin
            n_symbol_d = cfg_n_symbol;
            sc_start_d = cfg_sc_start;
            n_sc_d     = cfg_n_sc;
            mask_d     = cfg_dmrs_mask;
            comb_d     = cfg_dmrs_comb;
            bin_cnt_d  = '0;
            sym_cnt_d  = '0;
            state_d    = ST_MAP;
          end
        end
      end
      ST_MAP: begin
        if (adv) begin
          case (re_class)
            RE_DATA: begin
              d_ready = 1'b1;
              load    = d_valid;
              load_re = {{(WIDTH-D_W){d_re[D_W-1]}}, d_re};
              load_im = {{(WIDTH-D_W){d_im[D_W-1]}}, d_im};
            end
            RE_DMRS: begin
              rs_ready = 1'b1;
              load     = rs_valid;
              load_re  = {{(WIDTH-DMRS_W){rs_re[DMRS_W-1]}}, rs_re} << DMRS_SHIFT;
              load_im  = {{(WIDTH-DMRS_W){rs_im[DMRS_W-1]}}, rs_im} << DMRS_SHIFT;
            end
            default: load = 1'b1;
          endcase
          // A starved bin never turns into a zero: the register drains and the bin waits.
          out_valid_d = load;
          if (load) begin
            out_re_d  = load_re;
            out_im_d  = load_im;
            out_sop_d = (bin_cnt_q == '0);
            out_eop_d = (bin_cnt_q == AW'(N_FFT - 1));
            out_sym_d = sym_cnt_q;
            if (bin_cnt_q == AW'(N_FFT - 1)) begin
              bin_cnt_d = '0;
              if (sym_cnt_q == n_symbol_q - 4'd1) state_d = ST_FLUSH;
              else sym_cnt_d = sym_cnt_q + 4'd1;
            end else begin
              bin_cnt_d = bin_cnt_q + AW'(1);
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_valid_q && out_ready && out_eop_q) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bin_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      n_symbol_q  <= '0;
      sc_start_q  <= '0;
      n_sc_q      <= '0;
      mask_q      <= '0;
      comb_q      <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_sym_q   <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      n_symbol_q  <= n_symbol_d;
      sc_start_q  <= sc_start_d;
      n_sc_q      <= n_sc_d;
      mask_q      <= mask_d;
      comb_q      <= comb_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_sym_q   <= out_sym_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_sym   = out_sym_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pusch_re_mapper.sv
// Bench for pusch_re_mapper at N_FFT=64: directed configurations with ramp or
// random payloads, random back-pressure, checked against a frame-level model.
module tb_pusch_re_mapper;

  localparam int N      = 64;
  localparam int AW     = 6;
  localparam int WIDTH  = 26;
  localparam int D_W    = 18;
  localparam int DMRS_W = 9;

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic             sop;
    logic             eop;
    logic [3:0]       sym;
  } smp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        cfg_n_symbol = '0;
  logic [AW-1:0]     cfg_sc_start = '0;
  logic [AW:0]       cfg_n_sc = '0;
  logic [13:0]       cfg_dmrs_mask = '0;
  logic              cfg_dmrs_comb = 1'b0;
  logic [D_W-1:0]    d_re = '0, d_im = '0;
  logic              d_valid = 1'b0;
  logic              d_ready;
  logic [DMRS_W-1:0] rs_re = '0, rs_im = '0;
  logic              rs_valid = 1'b0;
  logic              rs_ready;
  logic [WIDTH-1:0]  out_re, out_im;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_sop, out_eop;
  logic [3:0]        out_sym;
  logic              busy, done, cfg_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pusch_re_mapper #(.N_FFT(N), .WIDTH(WIDTH), .D_W(D_W), .DMRS_W(DMRS_W), .DMRS_SHIFT(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_n_symbol(cfg_n_symbol), .cfg_sc_start(cfg_sc_start), .cfg_n_sc(cfg_n_sc),
    .cfg_dmrs_mask(cfg_dmrs_mask), .cfg_dmrs_comb(cfg_dmrs_comb),
    .d_re(d_re), .d_im(d_im), .d_valid(d_valid), .d_ready(d_ready),
    .rs_re(rs_re), .rs_im(rs_im), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .out_re(out_re), .out_im(out_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_sym(out_sym),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_re"}, 64'(out_re), 64'd0);
    chk({tag, "_im"}, 64'(out_im), 64'd0);
    chk({tag, "_flags"}, {out_valid, out_sop, out_eop, busy, done, cfg_err, d_ready, rs_ready}, 64'd0);
    chk({tag, "_sym"}, 64'(out_sym), 64'd0);
  endtask

  // Runs one slot: builds expected frame and input streams from the mapping rules,
  // drives random back-pressure, and checks every accepted sample in order.
  task automatic run_frame(input int nsym, input int scs, input int nsc, input logic [13:0] mask,
                           input bit comb, input bit ramp, input int stall, input int reset_at,
                           input bit poke);
    smp_t exp_q[$];
    int   dq_re[$], dq_im[$], rq_re[$], rq_im[$];
    smp_t e, obs, prev_pl;
    int   k, v_re, v_im, rs_total, rs_hs, accepted, total;
    bit   prev_hold, last_hs, poked, saw_done;
    rs_total = 0; rs_hs = 0; accepted = 0; prev_hold = 0; last_hs = 0; poked = 0; saw_done = 0;
    prev_pl = '0;
    for (int s = 0; s < nsym; s++) begin
      k = 0;
      for (int b = 0; b < N; b++) begin
        e = '0;
        e.sop = (b == 0);
        e.eop = (b == N - 1);
        e.sym = 4'(s);
        if (b >= scs && b < scs + nsc) begin
          if (mask[s]) begin
            if (!(comb && ((b - scs) % 2 == 1))) begin
              k++;
              v_re = ramp ? k : int'($urandom_range(511)) - 256;
              v_im = ramp ? -k : int'($urandom_range(511)) - 256;
              rq_re.push_back(v_re);
              rq_im.push_back(v_im);
              e.re = WIDTH'(v_re * 256);
              e.im = WIDTH'(v_im * 256);
            end
          end else begin
            k++;
            v_re = ramp ? 100 + k : int'($urandom_range(262143)) - 131072;
            v_im = ramp ? -(100 + k) : int'($urandom_range(262143)) - 131072;
            dq_re.push_back(v_re);
            dq_im.push_back(v_im);
            e.re = WIDTH'(v_re);
            e.im = WIDTH'(v_im);
          end
        end
        exp_q.push_back(e);
      end
    end
    rs_total = rq_re.size();
    total = exp_q.size();

    @(negedge clk);
    cfg_n_symbol = 4'(nsym); cfg_sc_start = AW'(scs); cfg_n_sc = (AW+1)'(nsc);
    cfg_dmrs_mask = mask; cfg_dmrs_comb = comb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", busy, 1);
    chk("no_early_valid", out_valid, 0);
    chk("cfg_err_clear", cfg_err, 0);

    for (int cyc = 0; cyc < 4000 && !saw_done; cyc++) begin
      start = 1'b0;
      if (poke && !poked && accepted == 20) begin
        start = 1'b1; cfg_n_symbol = 4'd1; cfg_sc_start = '0; cfg_dmrs_comb = ~comb;
        poked = 1;
      end
      out_ready = ($urandom_range(99) >= stall);
      d_valid   = (dq_re.size() > 0) && ($urandom_range(99) >= stall);
      d_re      = (dq_re.size() > 0) ? D_W'(dq_re[0]) : D_W'($urandom);
      d_im      = (dq_im.size() > 0) ? D_W'(dq_im[0]) : D_W'($urandom);
      rs_valid  = (rq_re.size() > 0) && ($urandom_range(99) >= stall);
      rs_re     = (rq_re.size() > 0) ? DMRS_W'(rq_re[0]) : DMRS_W'($urandom);
      rs_im     = (rq_im.size() > 0) ? DMRS_W'(rq_im[0]) : DMRS_W'($urandom);
      #1;
      chk("done_pulse", done, 64'(last_hs));
      if (last_hs) saw_done = 1;
      last_hs = 0;
      if (d_ready && rs_ready) chk("ready_exclusive", {d_ready, rs_ready}, 0);
      obs = {out_re, out_im, out_sop, out_eop, out_sym};
      if (prev_hold) chk("stall_stable", {out_valid, obs}, {1'b1, prev_pl});
      prev_hold = out_valid && !out_ready;
      prev_pl = obs;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_sample", accepted, total);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("sample_%0d", accepted), obs, e);
          accepted++;
          if (exp_q.size() == 0) last_hs = 1;
        end
      end
      if (d_valid && d_ready) begin
        void'(dq_re.pop_front()); void'(dq_im.pop_front());
      end
      if (rs_valid && rs_ready) begin
        void'(rq_re.pop_front()); void'(rq_im.pop_front()); rs_hs++;
      end
      if (reset_at > 0 && accepted == reset_at) begin
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0; d_valid = 1'b0; rs_valid = 1'b0;
        #1;
        chk_reset_outputs("midframe_reset");
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
    d_valid = 1'b0; rs_valid = 1'b0; start = 1'b0;
    chk("frame_complete", {saw_done, 32'(accepted)}, {1'b1, 32'(total)});
    chk("data_consumed", dq_re.size(), 0);
    chk("rs_handshakes", rs_hs, rs_total);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_frame_idle", {done, busy, out_valid}, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Ramp payloads, DMRS on every allocated bin of symbol 0.
    run_frame(2, 4, 12, 14'b01, 1'b0, 1'b1, 0, 0, 1'b0);
    // Comb DMRS: only even offsets consume a DMRS sample.
    run_frame(2, 4, 12, 14'b01, 1'b1, 1'b1, 0, 0, 1'b0);
    // Same geometry with random payloads and heavy stalls on both sides.
    run_frame(2, 4, 12, 14'b01, 1'b0, 1'b0, 50, 0, 1'b0);
    run_frame(3, 10, 24, 14'b101, 1'b1, 1'b0, 30, 0, 1'b0);
    // Window ending exactly at the last bin.
    run_frame(1, 40, 24, 14'b0, 1'b0, 1'b0, 20, 0, 1'b0);

    // Window overrunning N_FFT is rejected.
    @(negedge clk);
    cfg_n_symbol = 4'd2; cfg_sc_start = 6'd60; cfg_n_sc = 7'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("cfg_err_set", {cfg_err, busy}, 2'b10);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("cfg_err_no_output", {out_valid, busy, d_ready, rs_ready}, 0);
    end
    // Out-of-range symbol count is rejected too.
    @(negedge clk);
    cfg_n_symbol = 4'd15; cfg_sc_start = 6'd0; cfg_n_sc = 7'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("cfg_err_nsym", {cfg_err, busy}, 2'b10);
    run_frame(1, 0, 12, 14'b1, 1'b0, 1'b0, 10, 0, 1'b0);

    // Reset at sample 70, then a clean frame.
    run_frame(2, 4, 12, 14'b10, 1'b0, 1'b0, 25, 70, 1'b0);
    run_frame(2, 4, 12, 14'b10, 1'b0, 1'b1, 0, 0, 1'b0);

    // Start pulsed mid-frame with a different config must be ignored.
    run_frame(2, 8, 36, 14'b01, 1'b0, 1'b0, 20, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
